exu_ifetch_rcv: RTL and testbench

EXU-side receiver for the fetch handshake driven by the instruction fetch unit. It accepts the fetched instruction and PC on each valid/ready handshake into a small FIFO. It then presents them, in order, to the EXU decode stage through a second valid/ready pair. It also returns the length flag of the instruction being offered, drops all buffered instructions on a pipeline flush, and decouples the fetch-side ready from the decode-side ready so that no combinational ready path crosses the stage.

---
 rtl/exu_ifetch_rcv_if.sv | 28 ++
 rtl/exu_ifetch_rcv.sv | 76 +++++++
 tb/tb_exu_ifetch_rcv.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/exu_ifetch_rcv_if.sv
// Fetch-to-EXU handshake bundle: the fetch-side valid/ready pair plus the
// decode-side valid/ready pair seen by the EXU instruction receiver.
interface exu_ifetch_rcv_if #(
    parameter int PC_SIZE = 32,
    parameter int XLEN    = 32
);
    // Both pairs: a transfer completes on a rising edge where valid & ready are both high.
    logic               ifu_i_ifu_valid;
    logic               ifu_o_exu_ready;
    logic [XLEN-1:0]    ifu_i_ir;
    logic [PC_SIZE-1:0] ifu_i_pc;
    logic               ifu_o_rv32;
    logic               dec_o_valid;
    logic               dec_i_ready;
    logic [XLEN-1:0]    dec_o_ir;
    logic [PC_SIZE-1:0] dec_o_pc;
    logic               dec_o_rv32;

    modport master (
        output ifu_i_ifu_valid, ifu_i_ir, ifu_i_pc, dec_i_ready,
        input  ifu_o_exu_ready, ifu_o_rv32, dec_o_valid, dec_o_ir, dec_o_pc, dec_o_rv32
    );

    modport slave (
        input  ifu_i_ifu_valid, ifu_i_ir, ifu_i_pc, dec_i_ready,
        output ifu_o_exu_ready, ifu_o_rv32, dec_o_valid, dec_o_ir, dec_o_pc, dec_o_rv32
    );
endinterface

// File: rtl/exu_ifetch_rcv.sv
// EXU-side instruction receive buffer: small in-order FIFO between fetch and
// decode, flushable, with registered-only ready toward the fetch unit.
module exu_ifetch_rcv #(
    parameter int DEPTH   = 2,
    parameter int PC_SIZE = 32,
    parameter int XLEN    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     exu_i_flush,
    output logic [$clog2(DEPTH):0]   buf_o_count,
    exu_ifetch_rcv_if.slave          bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0]    ir_mem_q [DEPTH];
    logic [PC_SIZE-1:0] pc_mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               in_ready;
    logic               out_valid;
    logic               push;
    logic               pop;

    // Ready looks only at registered occupancy, so no path from dec_i_ready reaches the fetch side.
    assign in_ready  = rst_n & ~exu_i_flush & (count_q != FULL);
    assign out_valid = rst_n & ~exu_i_flush & (count_q != '0);
    assign push      = bus.ifu_i_ifu_valid & in_ready;
    assign pop       = out_valid & bus.dec_i_ready;

    assign bus.ifu_o_exu_ready = in_ready;
    assign bus.dec_o_valid     = out_valid;
    assign bus.ifu_o_rv32      = (bus.ifu_i_ir[1:0] == 2'b11);
    assign bus.dec_o_ir        = ir_mem_q[rd_ptr_q];
    assign bus.dec_o_pc        = pc_mem_q[rd_ptr_q];
    assign bus.dec_o_rv32      = (ir_mem_q[rd_ptr_q][1:0] == 2'b11);
    assign buf_o_count         = rst_n ? count_q : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (exu_i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the natural pointer overflow is the wrap.
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem_q[wr_ptr_q] <= bus.ifu_i_ir;
            pc_mem_q[wr_ptr_q] <= bus.ifu_i_pc;
        end
    end
endmodule

// File: tb/tb_exu_ifetch_rcv.sv
// Bench for exu_ifetch_rcv: directed fetch/decode traffic with a queue-based
// reference of buffered entries checked on every decode-side transfer.
module tb_exu_ifetch_rcv;
  localparam int DEPTH = 2;
  localparam int PC_SIZE = 32;
  localparam int XLEN = 32;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + PC_SIZE;

  logic clk;
  logic rst_n;
  logic exu_i_flush;
  logic [CW-1:0] buf_o_count;

  exu_ifetch_rcv_if #(.PC_SIZE(PC_SIZE), .XLEN(XLEN)) bus ();

  exu_ifetch_rcv #(.DEPTH(DEPTH), .PC_SIZE(PC_SIZE), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .exu_i_flush (exu_i_flush),
    .buf_o_count (buf_o_count),
    .bus         (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [EW-1:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic offer(input logic [XLEN-1:0] ir, input logic [PC_SIZE-1:0] pc);
    bus.ifu_i_ifu_valid = 1'b1;
    bus.ifu_i_ir = ir;
    bus.ifu_i_pc = pc;
  endtask

  task automatic idle_fetch();
    bus.ifu_i_ifu_valid = 1'b0;
  endtask

  // scoreboard monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    logic exp_ready, exp_valid;
    logic [EW-1:0] head;
    exp_ready = rst_n & ~exu_i_flush & (exp_q.size() != DEPTH);
    exp_valid = rst_n & ~exu_i_flush & (exp_q.size() != 0);
    chk("ifu_o_exu_ready", 64'(bus.ifu_o_exu_ready), 64'(exp_ready));
    chk("dec_o_valid", 64'(bus.dec_o_valid), 64'(exp_valid));
    chk("buf_o_count", 64'(buf_o_count), rst_n ? 64'(exp_q.size()) : 64'd0);
    if (exp_valid && bus.dec_i_ready) begin
      head = exp_q.pop_front();
      chk("dec_o_ir", 64'(bus.dec_o_ir), 64'(head[EW-1:PC_SIZE]));
      chk("dec_o_pc", 64'(bus.dec_o_pc), 64'(head[PC_SIZE-1:0]));
      chk("dec_o_rv32", 64'(bus.dec_o_rv32), 64'(head[PC_SIZE+1:PC_SIZE] == 2'b11));
    end
    if (bus.ifu_i_ifu_valid && exp_ready)
      exp_q.push_back({bus.ifu_i_ir, bus.ifu_i_pc});
    if (!rst_n || exu_i_flush)
      exp_q.delete();
  end

  initial begin
    rst_n = 1'b0;
    exu_i_flush = 1'b0;
    bus.ifu_i_ifu_valid = 1'b0;
    bus.ifu_i_ir = '0;
    bus.ifu_i_pc = '0;
    bus.dec_i_ready = 1'b0;
    tick();
    tick();
    chk("rst ready", 64'(bus.ifu_o_exu_ready), 64'd0);
    chk("rst valid", 64'(bus.dec_o_valid), 64'd0);
    chk("rst count", 64'(buf_o_count), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("release ready", 64'(bus.ifu_o_exu_ready), 64'd1);
    chk("release valid", 64'(bus.dec_o_valid), 64'd0);

    // stream of 5 with decode always ready
    bus.dec_i_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      offer(32'h0000_0013 + 32'(k), 32'h8000_0000 + 32'(4 * k));
      tick();
      chk("stream valid", 64'(bus.dec_o_valid), 64'd1);
      chk("stream head pc", 64'(bus.dec_o_pc), 64'h8000_0000 + 64'(4 * k));
      chk("stream count<=1", 64'(buf_o_count <= 1), 64'd1);
    end
    idle_fetch();
    tick();
    chk("stream drained", 64'(buf_o_count), 64'd0);

    // backpressure fill
    bus.dec_i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      offer(32'h0000_0013, 32'h8000_0000 + 32'(4 * k));
      tick();
      if (k == 0) chk("bp count 1", 64'(buf_o_count), 64'd1);
      if (k >= 1) begin
        chk("bp full ready", 64'(bus.ifu_o_exu_ready), 64'd0);
        chk("bp full count", 64'(buf_o_count), 64'd2);
        chk("bp head pc", 64'(bus.dec_o_pc), 64'h8000_0000);
      end
    end
    idle_fetch();
    bus.dec_i_ready = 1'b1;
    tick();
    chk("bp ready back", 64'(bus.ifu_o_exu_ready), 64'd1);
    chk("bp head after pop", 64'(bus.dec_o_pc), 64'h8000_0004);
    tick();
    chk("bp drained", 64'(buf_o_count), 64'd0);

    // length flag
    bus.dec_i_ready = 1'b0;
    offer(32'h0000_4501, 32'h8000_0040);
    #1;
    chk("ifu_o_rv32 16b", 64'(bus.ifu_o_rv32), 64'd0);
    tick();
    chk("head rv32 16b", 64'(bus.dec_o_rv32), 64'd0);
    chk("head ir 16b", 64'(bus.dec_o_ir), 64'h4501);
    offer(32'h00A0_0513, 32'h8000_0044);
    #1;
    chk("ifu_o_rv32 32b", 64'(bus.ifu_o_rv32), 64'd1);
    tick();
    idle_fetch();
    bus.dec_i_ready = 1'b1;
    tick();
    chk("head rv32 32b", 64'(bus.dec_o_rv32), 64'd1);
    chk("head ir 32b", 64'(bus.dec_o_ir), 64'h00A0_0513);
    tick();

    // flush with buffer full
    bus.dec_i_ready = 1'b0;
    offer(32'h0000_0013, 32'h8000_0080);
    tick();
    offer(32'h0000_0013, 32'h8000_0084);
    tick();
    chk("flush pre count", 64'(buf_o_count), 64'd2);
    offer(32'h0000_0013, 32'h8000_0088);
    bus.dec_i_ready = 1'b1;
    exu_i_flush = 1'b1;
    #1;
    chk("flush ready", 64'(bus.ifu_o_exu_ready), 64'd0);
    chk("flush valid", 64'(bus.dec_o_valid), 64'd0);
    tick();
    exu_i_flush = 1'b0;
    idle_fetch();
    #1;
    chk("flush count", 64'(buf_o_count), 64'd0);
    chk("flush empty valid", 64'(bus.dec_o_valid), 64'd0);
    offer(32'h0000_0013, 32'h8000_0100);
    tick();
    idle_fetch();
    chk("post flush valid", 64'(bus.dec_o_valid), 64'd1);
    chk("post flush pc", 64'(bus.dec_o_pc), 64'h8000_0100);
    tick();

    // wrap with simultaneous push/pop
    bus.dec_i_ready = 1'b1;
    offer(32'h0000_0013, 32'h8000_0200);
    tick();
    for (int i = 1; i <= 10; i++) begin
      offer(32'h0000_0013 + 32'(i), 32'h8000_0200 + 32'(4 * i));
      tick();
      chk("wrap count", 64'(buf_o_count), 64'd1);
      chk("wrap head pc", 64'(bus.dec_o_pc), 64'h8000_0200 + 64'(4 * i));
    end
    idle_fetch();
    tick();
    chk("wrap drained", 64'(buf_o_count), 64'd0);

    // synchronous reset with buffer full
    bus.dec_i_ready = 1'b0;
    offer(32'h0000_0013, 32'h8000_0300);
    tick();
    offer(32'h0000_0013, 32'h8000_0304);
    tick();
    idle_fetch();
    chk("pre-reset count", 64'(buf_o_count), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("mid rst ready", 64'(bus.ifu_o_exu_ready), 64'd0);
    chk("mid rst valid", 64'(bus.dec_o_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post rst count", 64'(buf_o_count), 64'd0);
    chk("post rst valid", 64'(bus.dec_o_valid), 64'd0);
    chk("post rst ready", 64'(bus.ifu_o_exu_ready), 64'd1);
    bus.dec_i_ready = 1'b1;
    tick();
    chk("no stale entry", 64'(bus.dec_o_valid), 64'd0);
    tick();

    chk("scoreboard empty", 64'(exp_q.size()), 64'd0);
    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
